// File: rtl/ram8_dmux_pkg.sv
// Shared constants for the RAM8 register bank and the blocks that reuse it.
package ram8_dmux_pkg;
    localparam int                WORD_W      = 16;
    localparam int                RAM8_ADDR_W = 3;
    localparam int                RAM8_DEPTH  = 8;
    localparam logic [WORD_W-1:0] WORD_RESET  = 16'h0000;
endpackage

// File: rtl/ram8_dmux_if.sv
// Data/control bundle for one RAM8 bank: write data, load strobe, address and read data.
interface ram8_dmux_if
    import ram8_dmux_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = RAM8_ADDR_W
);
    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  out;

    modport master (output in, output load, output address, input out);
    modport slave  (input in, input load, input address, output out);
endinterface

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer: routes a single strobe to the output selected by sel.
module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);
    assign a = in & (sel == 3'd0);
    assign b = in & (sel == 3'd1);
    assign c = in & (sel == 3'd2);
    assign d = in & (sel == 3'd3);
    assign e = in & (sel == 3'd4);
    assign f = in & (sel == 3'd5);
    assign g = in & (sel == 3'd6);
    assign h = in & (sel == 3'd7);
endmodule

// File: rtl/mux16.sv
// Word-wide 2:1 mux cell: out = sel ? b : a.
module mux16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? b : a;
endmodule

// File: rtl/ram8_dmux.sv
// 8 x WIDTH register bank: demuxed load strobe on the write side, mux tree on the read side.
module ram8_dmux
    import ram8_dmux_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    ram8_dmux_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] sel_v;
    logic [WIDTH-1:0] word [DEPTH];
    logic [WIDTH-1:0] lvl1 [4];
    logic [WIDTH-1:0] lvl2 [2];

    dmux8way u_dmux (
        .in  (bus.load),
        .sel (bus.address),
        .a   (sel_v[0]),
        .b   (sel_v[1]),
        .c   (sel_v[2]),
        .d   (sel_v[3]),
        .e   (sel_v[4]),
        .f   (sel_v[5]),
        .g   (sel_v[6]),
        .h   (sel_v[7])
    );

    // Reset has priority, so an unknown load/address during reset cannot reach the words.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                word[k] <= WIDTH'(WORD_RESET);
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (sel_v[k]) begin
                    word[k] <= bus.in;
                end
            end
        end
    end

    // Read tree: address[0] picks within pairs, address[2] makes the final choice.
    for (genvar i = 0; i < 4; i++) begin : g_lvl1
        mux16 #(.WIDTH(WIDTH)) u_mux (
            .a   (word[2*i]),
            .b   (word[2*i+1]),
            .sel (bus.address[0]),
            .out (lvl1[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_lvl2
        mux16 #(.WIDTH(WIDTH)) u_mux (
            .a   (lvl1[2*i]),
            .b   (lvl1[2*i+1]),
            .sel (bus.address[1]),
            .out (lvl2[i])
        );
    end

    mux16 #(.WIDTH(WIDTH)) u_mux_lvl3 (
        .a   (lvl2[0]),
        .b   (lvl2[1]),
        .sel (bus.address[2]),
        .out (bus.out)
    );
endmodule

// File: tb/tb_ram8_dmux.sv
// Bench for ram8_dmux: directed vector table, then random traffic against an array model.
module tb_ram8_dmux;
    import ram8_dmux_pkg::*;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] exp_out;
        int          test;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t vecs [$];
    logic [15:0] model [8];

    ram8_dmux_if bus ();

    ram8_dmux dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: out=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ld, input logic [2:0] a,
                       input logic [15:0] d, input logic [15:0] e, input int t);
        vec_t v;
        v.rst = rst; v.ld = ld; v.a = a; v.d = d; v.exp_out = e; v.test = t;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] tmp;
        errors = 0;
        checks = 0;

        // Reset edge with unknown control inputs.
        reset       = 1'b1;
        bus.load    = 1'bx;
        bus.address = 3'bxxx;
        bus.in      = 16'hDEAD;
        tick();
        reset    = 1'b0;
        bus.load = 1'b0;

        // Test 1: all zero after reset.
        for (int k = 0; k < 8; k++) add(0, 0, 3'(k), 16'h0000, 16'h0000, 1);
        // Test 2: write A500|k (old value visible during write), then read back.
        for (int k = 0; k < 8; k++) add(0, 1, 3'(k), 16'hA500 | 16'(k), 16'h0000, 2);
        for (int k = 0; k < 8; k++) add(0, 0, 3'(k), 16'h0000, 16'hA500 | 16'(k), 2);
        // Test 3: word3 <- 0003, then BEEF with read-during-write.
        add(0, 1, 3'd3, 16'h0003, 16'hA503, 3);
        add(0, 1, 3'd3, 16'hBEEF, 16'h0003, 3);
        add(0, 0, 3'd3, 16'h0000, 16'hBEEF, 3);
        // Test 4: load=0 ignores in.
        for (int k = 0; k < 8; k++) begin
            tmp = (k == 3) ? 16'hBEEF : (16'hA500 | 16'(k));
            add(0, 0, 3'(k), 16'hFFFF, tmp, 4);
        end
        // Test 6: back-to-back writes.
        add(0, 1, 3'd7, 16'h8001, 16'hA507, 6);
        add(0, 1, 3'd0, 16'h7FFE, 16'hA500, 6);
        add(0, 1, 3'd7, 16'h0F0F, 16'h8001, 6);
        for (int k = 0; k < 8; k++) begin
            tmp = (k == 0) ? 16'h7FFE : (k == 7) ? 16'h0F0F :
                  (k == 3) ? 16'hBEEF : (16'hA500 | 16'(k));
            add(0, 0, 3'(k), 16'h0000, tmp, 6);
        end
        // Test 5: reset dominates a simultaneous write.
        add(1, 1, 3'd5, 16'h1234, 16'hA505, 5);
        for (int k = 0; k < 8; k++) add(0, 0, 3'(k), 16'h0000, 16'h0000, 5);

        foreach (vecs[i]) begin
            reset       = vecs[i].rst;
            bus.load    = vecs[i].ld;
            bus.address = vecs[i].a;
            bus.in      = vecs[i].d;
            #1;
            check($sformatf("vec_t%0d", vecs[i].test), i, bus.out, vecs[i].exp_out);
            tick();
        end

        // Random traffic; contents are all zero at this point.
        for (int k = 0; k < 8; k++) model[k] = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 31) == 0);
            bus.load    = $urandom_range(0, 1) == 1;
            bus.address = 3'($urandom_range(0, 7));
            bus.in      = 16'($urandom);
            #1;
            check("rand_pre", i, bus.out, model[bus.address]);
            if (reset) begin
                for (int k = 0; k < 8; k++) model[k] = 16'h0000;
            end else if (bus.load) begin
                model[bus.address] = bus.in;
            end
            tick();
        end

        // Final sweep of every word against the model.
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.address = 3'(k);
            #1;
            check("final", k, bus.out, model[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
